// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds active-area pixel coordinates from hsync/vsync/de,
// measures line and frame geometry, and reports lock against H_RES x V_RES.
module vga_sync_decoder #(
  parameter int unsigned H_RES     = 800,
  parameter int unsigned V_RES     = 480,
  parameter bit          HS_ACTIVE = 1'b0,
  parameter bit          VS_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        active,
  output logic        frame_start,
  output logic [11:0] line_len,
  output logic [9:0]  act_width,
  output logic [9:0]  act_lines,
  output logic        locked,
  output logic        err
);

  localparam logic [9:0] H_RES_W = 10'(H_RES);
  localparam logic [9:0] V_RES_W = 10'(V_RES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs1_q, hs2_q, vs1_q, vs2_q, de1_q, de2_q;
  logic [11:0] hcnt_q, hcnt_d, line_len_q, line_len_d, ref_len_q, ref_len_d;
  logic        ref_valid_q, ref_valid_d;
  logic [9:0]  px_q, px_d, ln_q, ln_d, sx_q, sx_d, sy_q, sy_d;
  logic [9:0]  act_width_q, act_width_d, act_lines_q, act_lines_d;
  logic        active_q, active_d, frame_start_q, frame_start_d, err_q, err_d;

  logic        hs_lead, vs_lead, de_rise, de_fall, hcnt_sat, geom_bad, lines_ok;
  logic [11:0] hcnt_inc;
  logic [9:0]  px_inc, ln_inc;

  assign hs_lead  = (hs1_q == HS_ACTIVE) && (hs2_q != HS_ACTIVE);
  assign vs_lead  = (vs1_q == VS_ACTIVE) && (vs2_q != VS_ACTIVE);
  assign de_rise  = de1_q && !de2_q;
  assign de_fall  = !de1_q && de2_q;
  assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + 12'd1;
  assign px_inc   = (px_q == '1) ? px_q : px_q + 10'd1;
  assign ln_inc   = (ln_q == '1) ? ln_q : ln_q + 10'd1;

  // A missing hsync is reported once, on the cycle hcnt first pins at 4095.
  assign hcnt_sat = !hs_lead && (hcnt_q == 12'hFFE);
  assign geom_bad = (hs_lead && ref_valid_q && (hcnt_inc != ref_len_q))
                  || (de_fall && (px_inc != H_RES_W))
                  || hcnt_sat;
  assign lines_ok = (ln_q == V_RES_W);

  always_comb begin
    hcnt_d        = hcnt_inc;
    line_len_d    = line_len_q;
    px_d          = px_q;
    ln_d          = ln_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    act_width_d   = act_width_q;
    act_lines_d   = act_lines_q;
    active_d      = de1_q;
    frame_start_d = vs_lead;
    if (hs_lead) begin
      line_len_d = hcnt_inc;
      hcnt_d     = '0;
    end
    if (de1_q) begin
      px_d = de_rise ? '0 : px_inc;
      sx_d = px_d;
      sy_d = ln_q;
    end
    if (de_fall) begin
      act_width_d = px_inc;
      ln_d        = ln_inc;
    end
    if (vs_lead) begin
      act_lines_d = ln_q;
      ln_d        = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    ref_valid_d = ref_valid_q;
    err_d       = 1'b0;
    case (state_q)
      SEARCH: begin
        ref_valid_d = 1'b0;
        if (vs_lead) state_d = MEASURE;
      end
      MEASURE: begin
        if (hs_lead && !ref_valid_q) begin
          ref_len_d   = hcnt_inc;
          ref_valid_d = 1'b1;
        end
        if (geom_bad)     state_d = SEARCH;
        else if (vs_lead) state_d = lines_ok ? LOCKED : SEARCH;
      end
      LOCKED: begin
        if (geom_bad || (vs_lead && !lines_ok)) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      hs1_q         <= !HS_ACTIVE;
      hs2_q         <= !HS_ACTIVE;
      vs1_q         <= !VS_ACTIVE;
      vs2_q         <= !VS_ACTIVE;
      de1_q         <= 1'b0;
      de2_q         <= 1'b0;
      hcnt_q        <= '0;
      line_len_q    <= '0;
      ref_len_q     <= '0;
      ref_valid_q   <= 1'b0;
      px_q          <= '0;
      ln_q          <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      act_width_q   <= '0;
      act_lines_q   <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs1_q         <= hsync;
      hs2_q         <= hs1_q;
      vs1_q         <= vsync;
      vs2_q         <= vs1_q;
      de1_q         <= de;
      de2_q         <= de1_q;
      hcnt_q        <= hcnt_d;
      line_len_q    <= line_len_d;
      ref_len_q     <= ref_len_d;
      ref_valid_q   <= ref_valid_d;
      px_q          <= px_d;
      ln_q          <= ln_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      act_width_q   <= act_width_d;
      act_lines_q   <= act_lines_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign act_width   = act_width_q;
  assign act_lines   = act_lines_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 40x12 raster
// (H 40/4/8/6 = 58 clocks, V 12/2/2/4 = 20 lines, active-low syncs).
module tb_vga_sync_decoder;
  logic        clk = 1'b0;
  logic        rst, hsync, vsync, de;
  logic [9:0]  sx, sy, act_width, act_lines;
  logic        active, frame_start, locked, err;
  logic [11:0] line_len;

  int n_assert = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int lock_cnt = 0;
  int base, lbase;

  int gx = 0, gy = 0, g_cyc = 0;
  int h_act_cur = 40, fp_cur = 4, h_act_req = 40;
  int short_seq = 0, short_done = 0, kill_until = 0;
  bit g_hs_lead, g_vs_lead, g_de_rise, g_last, g_short;
  bit hs_n, vs_n, de_n;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_RES(40),
    .V_RES(12),
    .HS_ACTIVE(1'b0),
    .VS_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .sx(sx), .sy(sy), .active(active), .frame_start(frame_start),
    .line_len(line_len), .act_width(act_width), .act_lines(act_lines),
    .locked(locked), .err(err)
  );

  always @(posedge clk) begin
    if (err)    err_cnt  <= err_cnt + 1;
    if (locked) lock_cnt <= lock_cnt + 1;
  end

  // Raster source, driven on the falling edge.
  initial begin
    hsync = 1'b1; vsync = 1'b1; de = 1'b0;
    forever begin
      @(negedge clk);
      if (gx == 0) begin
        h_act_cur  = h_act_req;
        g_short    = (short_seq != short_done);
        short_done = short_seq;
        fp_cur     = g_short ? 3 : 4;
      end
      hs_n = !(gx >= h_act_cur + fp_cur && gx < h_act_cur + fp_cur + 8) || (g_cyc < kill_until);
      vs_n = !(gy >= 14 && gy < 16);
      de_n = (gx < h_act_cur) && (gy < 12);
      g_hs_lead = hsync && !hs_n;
      g_vs_lead = vsync && !vs_n;
      g_de_rise = !de && de_n;
      g_last    = (gx == h_act_cur - 1) && (gy == 11);
      hsync = hs_n; vsync = vs_n; de = de_n;
      if (gx == h_act_cur + fp_cur + 13) begin
        gx = 0;
        gy = (gy == 19) ? 0 : gy + 1;
      end else begin
        gx = gx + 1;
      end
      g_cyc = g_cyc + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // sel: 0 vsync lead, 1 hsync lead, 2 de rise, 3 short-line hsync lead,
  // 4 err seen high, 5 last pixel of last active line driven
  task automatic wait_evt(input int sel, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      case (sel)
        0: hit = g_vs_lead;
        1: hit = g_hs_lead;
        2: hit = g_de_rise;
        3: hit = g_hs_lead && g_short;
        4: hit = (err === 1'b1);
        default: hit = g_last;
      endcase
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sx"}, 32'(sx), 0);
    chk({tag, "_sy"}, 32'(sy), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_act_width"}, 32'(act_width), 0);
    chk({tag, "_act_lines"}, 32'(act_lines), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // First frame edge, first pixel, last pixel, lock on second vsync.
    wait_evt(0, 2500, "wait_vs1");
    tick(); chk("fs_early", 32'(frame_start), 0);
    tick(); chk("fs_pulse", 32'(frame_start), 1); chk("locked_after_vs1", 32'(locked), 0);
    tick(); chk("fs_single", 32'(frame_start), 0);
    wait_evt(2, 1500, "wait_de_rise");
    tick(); chk("active_early", 32'(active), 0);
    tick(); chk("first_active", 32'(active), 1);
    chk("first_sx", 32'(sx), 0); chk("first_sy", 32'(sy), 0);
    wait_evt(5, 1500, "wait_last_px");
    tick(); tick();
    chk("last_sx", 32'(sx), 39); chk("last_sy", 32'(sy), 11); chk("last_active", 32'(active), 1);
    wait_evt(0, 1500, "wait_vs2");
    tick(); chk("locked_early", 32'(locked), 0);
    tick(); chk("locked_vs2", 32'(locked), 1);
    chk("line_len", 32'(line_len), 58);
    chk("act_width", 32'(act_width), 40);
    chk("act_lines", 32'(act_lines), 12);

    // One line shortened to 57 clocks while locked.
    base = err_cnt;
    short_seq++;
    wait_evt(3, 200, "wait_short_hs");
    tick(); chk("short_err_early", 32'(err), 0); chk("short_locked_early", 32'(locked), 1);
    tick(); chk("short_err", 32'(err), 1); chk("short_locked_drop", 32'(locked), 0);
    chk("short_line_len", 32'(line_len), 57);
    tick(); chk("short_err_end", 32'(err), 0);
    wait_evt(0, 1500, "wait_vs_a");
    tick(); tick(); chk("relock_not_yet", 32'(locked), 0);
    wait_evt(0, 1500, "wait_vs_b");
    tick(); tick(); chk("relock", 32'(locked), 1);
    chk("short_err_count", 32'(err_cnt - base), 1);

    // hsync held off for 5000 clocks while locked.
    wait_evt(0, 1500, "wait_vs_kill");
    base = err_cnt;
    kill_until = g_cyc + 5000;
    wait_evt(4, 4400, "wait_sat_err");
    chk("sat_locked_drop", 32'(locked), 0);
    wait_evt(1, 2000, "wait_hs_resume");
    tick(); tick(); chk("sat_line_len", 32'(line_len), 4095);
    chk("sat_err_count", 32'(err_cnt - base), 1);
    wait_evt(0, 1500, "wait_vs_r1");
    wait_evt(0, 1500, "wait_vs_r2");
    tick(); tick(); chk("relock_after_sat", 32'(locked), 1);

    // One-cycle reset in the middle of an active line.
    wait_evt(2, 1500, "wait_de_mid");
    repeat (5) tick();
    chk("pre_rst_sx", 32'(sx), 3); chk("pre_rst_locked", 32'(locked), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    wait_evt(0, 1500, "wait_vs_p1");
    tick(); tick(); chk("post_rst_locked_vs1", 32'(locked), 0);
    wait_evt(0, 1500, "wait_vs_p2");
    tick(); chk("post_rst_locked_early", 32'(locked), 0);
    tick(); chk("post_rst_relock", 32'(locked), 1);

    // Narrower 32-pixel stream from reset: measured but never locked.
    rst = 1'b1;
    h_act_req = 32;
    wait_evt(0, 2500, "wait_vs_narrow");
    rst = 1'b0;
    lbase = lock_cnt;
    base = err_cnt;
    repeat (3) wait_evt(0, 1500, "wait_vs_narrow_n");
    tick(); tick();
    chk("narrow_act_width", 32'(act_width), 32);
    chk("narrow_line_len", 32'(line_len), 50);
    chk("narrow_act_lines", 32'(act_lines), 12);
    chk("narrow_locked", 32'(locked), 0);
    chk("narrow_lock_cycles", 32'(lock_cnt - lbase), 0);
    chk("narrow_err_count", 32'(err_cnt - base), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
